// File: rtl/debounce_safe_pulse_emitter.sv
// Purpose : turns single-cycle event strobes into off-chip pulses with guaranteed
//           high width (highCycles) and minimum low width (lowCycles); strobes that
//           arrive mid-pulse are queued in a saturating counter and replayed.
// Latency : dataOut rises at the same edge that samples pulseIn when idle; queued
//           events start every highCycles+lowCycles clocks.
// Backpressure: none upstream; events beyond the queue depth are dropped and
//           flagged with a one-cycle overflow strobe.
//
// Ports:
//   clock        - system clock, all logic on the rising edge
//   reset        - synchronous, active-high
//   pulseIn      - event strobe, each high cycle is one event
//   dataOut      - registered pulse output to the pin
//   busy         - registered, high while a pulse is active or events are queued
//   pendingCount - registered number of queued, not yet started events
//   overflow     - registered one-cycle strobe, an event was dropped
module debounce_safe_pulse_emitter #(
    parameter int timerWidth   = 4,
    parameter int highCycles   = 5,
    parameter int lowCycles    = 5,
    parameter int pendingWidth = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    pulseIn,
    output logic                    dataOut,
    output logic                    busy,
    output logic [pendingWidth-1:0] pendingCount,
    output logic                    overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Timer counts down to zero, so a phase of N clocks reloads with N-1.
    localparam logic [timerWidth-1:0]   HIGH_RELOAD = timerWidth'(highCycles - 1);
    localparam logic [timerWidth-1:0]   LOW_RELOAD  = timerWidth'(lowCycles - 1);
    localparam logic [pendingWidth-1:0] PEND_MAX    = {pendingWidth{1'b1}};

    state_t                  state_q, state_d;
    logic [timerWidth-1:0]   timer_q, timer_d;
    logic [pendingWidth-1:0] pend_q, pend_d;
    logic                    data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    ovf_q, ovf_d;
    logic                    enqueue;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        ovf_d   = 1'b0;
        enqueue = 1'b0;

        case (state_q)
            IDLE: begin
                // The queue is always empty here: LOW never drops to IDLE with
                // events pending, so a strobe starts a pulse immediately.
                if (pulseIn) begin
                    state_d = HIGH;
                    timer_d = HIGH_RELOAD;
                end
            end
            HIGH: begin
                enqueue = pulseIn;
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    state_d = LOW;
                    timer_d = LOW_RELOAD;
                end
            end
            LOW: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                    enqueue = pulseIn;
                end else if (pulseIn) begin
                    // A fresh strobe on the last low cycle is consumed directly;
                    // it is not older than queued ones in any observable sense
                    // since every event yields an identical pulse.
                    state_d = HIGH;
                    timer_d = HIGH_RELOAD;
                end else if (pend_q != '0) begin
                    state_d = HIGH;
                    timer_d = HIGH_RELOAD;
                    pend_d  = pend_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        // Dequeue only happens when pulseIn is low, so it never collides with
        // an enqueue in the same cycle.
        if (enqueue) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end

        data_d = (state_d == HIGH);
        busy_d = (state_d != IDLE) || (pend_d != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dataOut      = data_q;
    assign busy         = busy_q;
    assign pendingCount = pend_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_debounce_safe_pulse_emitter.sv
// Purpose : directed bench for debounce_safe_pulse_emitter with default parameters.
// Latency : inputs driven at falling edge, outputs sampled 1 ns after rising edge.
// Backpressure: n/a.
module tb_debounce_safe_pulse_emitter;

    logic       clock;
    logic       reset;
    logic       pulseIn;
    logic       dataOut;
    logic       busy;
    logic [2:0] pendingCount;
    logic       overflow;

    debounce_safe_pulse_emitter #(
        .timerWidth  (4),
        .highCycles  (5),
        .lowCycles   (5),
        .pendingWidth(3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pulseIn     (pulseIn),
        .dataOut     (dataOut),
        .busy        (busy),
        .pendingCount(pendingCount),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    typedef struct {
        logic       p;
        logic       r;
        logic       d;
        logic       b;
        logic [2:0] pc;
        logic       o;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Output pulse monitor, updated once per step.
    int   rises, bad_hi, short_lo, hi_run, lo_run, ovf_seen;
    logic prev_d, seen_pulse;

    // Far-end debouncer model: 2 sync flops, 2-bit timer initialised to 3.
    logic       sy1, sy2, stable;
    logic [1:0] dcnt;
    int         deb_rises;

    always @(posedge clock) begin
        if (reset) begin
            sy1 <= 1'b0; sy2 <= 1'b0; stable <= 1'b0; dcnt <= 2'd3;
        end else begin
            sy1 <= dataOut;
            sy2 <= sy1;
            if (sy2 != stable) begin
                if (dcnt == 2'd0) begin
                    stable <= sy2;
                    dcnt   <= 2'd3;
                    if (sy2) deb_rises <= deb_rises + 1;
                end else begin
                    dcnt <= dcnt - 2'd1;
                end
            end else begin
                dcnt <= 2'd3;
            end
        end
    end

    function automatic void add(input logic p, input logic r, input logic d,
                                input logic b, input logic [2:0] pc, input logic o);
        vec_t v;
        v.p = p; v.r = r; v.d = d; v.b = b; v.pc = pc; v.o = o;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_mon();
        rises = 0; bad_hi = 0; short_lo = 0; hi_run = 0; lo_run = 0; ovf_seen = 0;
        prev_d = dataOut; seen_pulse = 1'b0;
    endtask

    task automatic step(input logic p, input logic r);
        @(negedge clock);
        pulseIn = p;
        reset   = r;
        @(posedge clock);
        #1;
        if (overflow) ovf_seen++;
        if (dataOut && !prev_d) begin
            rises++;
            if (seen_pulse && lo_run < 5) short_lo++;
            seen_pulse = 1'b1;
            hi_run = 0;
        end
        if (!dataOut && prev_d) begin
            if (hi_run != 5) bad_hi++;
            lo_run = 0;
        end
        if (dataOut) hi_run++;
        else lo_run++;
        prev_d = dataOut;
    endtask

    initial begin
        pulseIn   = 1'b0;
        reset     = 1'b1;
        deb_rises = 0;

        // Reset behaviour, then scenario 1 (single strobe) and scenario 2
        // (three consecutive strobes), one record per clock edge.
        add(0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0);                              // E
        for (int i = 1; i <= 4; i++) add(0, 0, 1, 1, 0, 0); // E+1..E+4
        for (int i = 5; i <= 9; i++) add(0, 0, 0, 1, 0, 0); // E+5..E+9
        add(0, 0, 0, 0, 0, 0);                              // E+10 idle
        add(0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0);                              // E
        add(1, 0, 1, 1, 1, 0);                              // E+1
        add(1, 0, 1, 1, 2, 0);                              // E+2
        for (int i = 3; i <= 4; i++)   add(0, 0, 1, 1, 2, 0);
        for (int i = 5; i <= 9; i++)   add(0, 0, 0, 1, 2, 0);
        for (int i = 10; i <= 14; i++) add(0, 0, 1, 1, 1, 0);
        for (int i = 15; i <= 19; i++) add(0, 0, 0, 1, 1, 0);
        for (int i = 20; i <= 24; i++) add(0, 0, 1, 1, 0, 0);
        for (int i = 25; i <= 29; i++) add(0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);                              // E+30 idle

        clr_mon();
        foreach (vecs[i]) begin
            step(vecs[i].p, vecs[i].r);
            chk($sformatf("vec%0d dataOut", i), int'(dataOut), int'(vecs[i].d));
            chk($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].b));
            chk($sformatf("vec%0d pendingCount", i), int'(pendingCount), int'(vecs[i].pc));
            chk($sformatf("vec%0d overflow", i), int'(overflow), int'(vecs[i].o));
        end
        chk("table pulse count", rises, 4);
        chk("table high width errors", bad_hi, 0);

        // Saturation: 9 consecutive strobes.
        clr_mon();
        for (int k = 1; k <= 9; k++) begin
            step(1, 0);
            chk($sformatf("sat pending after strobe %0d", k), int'(pendingCount),
                (k - 1 > 7) ? 7 : k - 1);
            chk($sformatf("sat overflow after strobe %0d", k), int'(overflow),
                (k == 9) ? 1 : 0);
        end
        step(0, 0);
        chk("sat overflow cleared", int'(overflow), 0);
        chk("sat pending held", int'(pendingCount), 7);
        for (int c = 0; c < 100; c++) step(0, 0);
        chk("sat pulse count", rises, 8);
        chk("sat high width errors", bad_hi, 0);
        chk("sat short low gaps", short_lo, 0);
        chk("sat overflow strobes", ovf_seen, 1);
        chk("sat busy cleared", int'(busy), 0);

        // Reset mid-HIGH with two events queued.
        step(1, 0);
        step(1, 0);
        step(1, 1);
        chk("rst dataOut", int'(dataOut), 0);
        chk("rst pendingCount", int'(pendingCount), 0);
        chk("rst busy", int'(busy), 0);
        clr_mon();
        for (int c = 0; c < 30; c++) step(0, 0);
        chk("rst no pulses after release", rises, 0);

        // Strobe landing exactly on the last LOW cycle is consumed directly.
        clr_mon();
        step(1, 0);
        for (int c = 1; c <= 9; c++) step(0, 0);
        chk("direct E+9 dataOut", int'(dataOut), 0);
        chk("direct E+9 busy", int'(busy), 1);
        step(1, 0);
        chk("direct E+10 dataOut", int'(dataOut), 1);
        chk("direct E+10 pendingCount", int'(pendingCount), 0);
        chk("direct E+10 busy", int'(busy), 1);
        for (int c = 11; c <= 14; c++) step(0, 0);
        chk("direct E+14 dataOut", int'(dataOut), 1);
        step(0, 0);
        chk("direct E+15 dataOut", int'(dataOut), 0);
        for (int c = 16; c <= 20; c++) step(0, 0);
        chk("direct idle busy", int'(busy), 0);
        chk("direct pulse count", rises, 2);
        chk("direct high width errors", bad_hi, 0);

        // Random bursts through the far-end debouncer model.
        begin
            int sent;
            int deb0;
            sent = 0;
            deb0 = deb_rises;
            clr_mon();
            for (int b = 0; b < 12; b++) begin
                int n;
                n = int'($urandom_range(1, 5));
                for (int k = 0; k < n; k++) step(1, 0);
                sent += n;
                for (int c = 0; c < n * 10 + int'($urandom_range(2, 8)); c++) step(0, 0);
            end
            for (int c = 0; c < 20; c++) step(0, 0);
            chk("burst emitted pulses", rises, sent);
            chk("burst debounced pulses", deb_rises - deb0, sent);
            chk("burst high width errors", bad_hi, 0);
            chk("burst short low gaps", short_lo, 0);
            chk("burst no overflow", ovf_seen, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
